// File: rtl/hilo_muldiv_if.sv
// HI/LO mul/div request/result bundle between the EX-stage issue logic and
// the hilo_muldiv engine. master = CPU side, slave = engine side.
interface hilo_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (output start, op, a, b, input busy, done, hi_out, lo_out);
  modport slave  (input start, op, a, b, output busy, done, hi_out, lo_out);
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a radix-2 iterative multiply/divide engine.
// MULT/MULTU/DIV/DIVU take DATA_W RUN edges plus one FIX edge; MTHI/MTLO
// write directly when idle. All state moves on the falling edge of clk so
// the block lines up with the rest of the HI/LO path.
// Optional feature: define HILO_MADD_EN to make op=111 a signed
// multiply-accumulate into {HI,LO}; otherwise op=111 behaves as NOP.
module hilo_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(DATA_W);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b111;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state;
  logic [DATA_W-1:0] hi_r, lo_r;
  logic [DATA_W-1:0] acc_hi;   // product high half / partial remainder
  logic [DATA_W-1:0] acc_lo;   // multiplier shifting out / dividend->quotient
  logic [DATA_W-1:0] m_r;      // |multiplicand| or |divisor|
  logic [CW-1:0]     cnt;
  logic              busy_r, done_r;
  logic              is_div, neg_q, neg_r, div0;
`ifdef HILO_MADD_EN
  logic              is_madd;
`endif

  // request decode and operand magnitudes
  logic              op_mul, op_div, op_signed;
  logic [DATA_W-1:0] mag_a, mag_b;
  always_comb begin
    op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`ifdef HILO_MADD_EN
    op_mul    = op_mul || (bus.op == OP_MADD);
    op_signed = op_signed || (bus.op == OP_MADD);
`endif
    mag_a = (op_signed && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    mag_b = (op_signed && bus.b[DATA_W-1]) ? -bus.b : bus.b;
  end

  // one radix-2 step: shift-add for multiply, restoring subtract for divide
  logic [DATA_W:0]   add_sum, rem_sh, rem_diff;
  logic [DATA_W-1:0] step_hi, step_lo;
  always_comb begin
    add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_r} : '0);
    rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, m_r};
    if (is_div) begin
      // remainder < divisor, so a kept value always fits DATA_W bits
      step_hi = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], ~rem_diff[DATA_W]};
    end else begin
      step_hi = add_sum[DATA_W:1];
      step_lo = {add_sum[0], acc_lo[DATA_W-1:1]};
    end
  end

  // sign fix-up of the unsigned result (and accumulate) written in FIX
  logic [2*DATA_W-1:0] prod, mul_res;
  logic [DATA_W-1:0]   quo, rem;
  always_comb begin
    prod    = {acc_hi, acc_lo};
    mul_res = neg_q ? -prod : prod;
`ifdef HILO_MADD_EN
    if (is_madd) mul_res = mul_res + {hi_r, lo_r};
`endif
    // divide-by-zero: restoring steps already leave rem=|a|, quo=all ones
    quo = (neg_q && !div0) ? -acc_lo : acc_lo;
    rem = neg_r ? -acc_hi : acc_hi;
  end

  // control FSM and HI/LO registers
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      hi_r   <= '0;
      lo_r   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m_r    <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`ifdef HILO_MADD_EN
      is_madd <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MTHI) begin
              hi_r <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_r <= bus.a;
            end else if (op_mul || op_div) begin
              state  <= S_RUN;
              busy_r <= 1'b1;
              cnt    <= CW'(DATA_W - 1);
              is_div <= op_div;
              neg_q  <= op_signed & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
              neg_r  <= op_signed & bus.a[DATA_W-1] & op_div;
              div0   <= op_div & (bus.b == '0);
              acc_hi <= '0;
              acc_lo <= op_div ? mag_a : mag_b;
              m_r    <= op_div ? mag_b : mag_a;
`ifdef HILO_MADD_EN
              is_madd <= (bus.op == OP_MADD);
`endif
            end
          end
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          if (is_div) begin
            hi_r <= rem;
            lo_r <= quo;
          end else begin
            {hi_r, lo_r} <= mul_res;
          end
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;
endmodule
